// File: rtl/regfile_sb_if.sv
// Port bundle for regfile_sb: write-back writes, decode reads and reservations, debug view.
// The master side is the pipeline (decode + write-back); the slave side is the register file.
interface regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
);
    logic [ADDR_W-1:0]          dstE;
    logic [DATA_W-1:0]          valE;
    logic [ADDR_W-1:0]          dstM;
    logic [DATA_W-1:0]          valM;
    logic [ADDR_W-1:0]          srcA;
    logic [ADDR_W-1:0]          srcB;
    logic [DATA_W-1:0]          valA;
    logic [DATA_W-1:0]          valB;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_dst;
    logic                       busyA;
    logic                       busyB;
    logic                       hazard;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    modport master (
        output dstE, valE, dstM, valM, srcA, srcB, rsv_en, rsv_dst,
        input  valA, valB, busyA, busyB, hazard, regs_flat
    );

    modport slave (
        input  dstE, valE, dstM, valM, srcA, srcB, rsv_en, rsv_dst,
        output valA, valB, busyA, busyB, hazard, regs_flat
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports and a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data and clears busy on retiring writes.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4,
    parameter int RNONE    = 15
) (
    input  logic         clock,
    input  logic         reset,
    regfile_sb_if.slave  rf
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [NUM_REGS-1:0] weE, weM, rsvOh, srcAOh, srcBOh;
    logic [DATA_W-1:0]   rdA, rdB;
    logic                rdBusyA, rdBusyB;

    // One-hot select; out-of-range IDs and RNONE decode to all zeros, which makes them no-ops.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] id);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (id == ADDR_W'(i) && id != ADDR_W'(RNONE)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign weE    = decode(rf.dstE);
    assign weM    = decode(rf.dstM);
    assign rsvOh  = rf.rsv_en ? decode(rf.rsv_dst) : '0;
    assign srcAOh = decode(rf.srcA);
    assign srcBOh = decode(rf.srcB);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (weM[i])      regs[i] <= rf.valM;
                else if (weE[i]) regs[i] <= rf.valE;
            end
            // A new reservation beats a retiring write to the same register.
            busy <= (busy & ~(weE | weM)) | rsvOh;
        end
    end

    always_comb begin
        rdA     = '0;
        rdB     = '0;
        rdBusyA = 1'b0;
        rdBusyB = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (srcAOh[i]) begin
                rdA     = regs[i];
                rdBusyA = busy[i];
            end
            if (srcBOh[i]) begin
                rdB     = regs[i];
                rdBusyB = busy[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset so every read port reads zero while it is held.
        if (reset) begin
            if (|(srcAOh & weM))      rdA = rf.valM;
            else if (|(srcAOh & weE)) rdA = rf.valE;
            if (|(srcBOh & weM))      rdB = rf.valM;
            else if (|(srcBOh & weE)) rdB = rf.valE;
            if (|(srcAOh & (weE | weM)) && !(|(srcAOh & rsvOh))) rdBusyA = 1'b0;
            if (|(srcBOh & (weE | weM)) && !(|(srcBOh & rsvOh))) rdBusyB = 1'b0;
        end
`endif
    end

    assign rf.valA   = rdA;
    assign rf.valB   = rdB;
    assign rf.busyA  = rdBusyA;
    assign rf.busyB  = rdBusyB;
    assign rf.hazard = rdBusyA | rdBusyB;

    always_comb begin
        rf.regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rf.regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string           nm;
        logic [DW-1:0]   valA;
        logic [DW-1:0]   valB;
        logic            busyA;
        logic            busyB;
        logic [NR*DW-1:0] flat;
    } exp_t;

    logic clock;
    logic reset;
    logic chkReq;
    int   checks;
    int   failures;
    exp_t q[$];
    exp_t e;
    logic [DW-1:0] expRegs [NR];

    regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) rfIf ();

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RNONE(15)) dut (
        .clock (clock),
        .reset (reset),
        .rf    (rfIf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exv);
        checks++;
        if (act !== exv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exv);
        end
    endtask

    // Monitor: pops one expectation per requested observation, mid-cycle.
    always @(negedge clock) begin
        if (chkReq) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = q.pop_front();
                cmp({e.nm, "_valA"},   256'(rfIf.valA),      256'(e.valA));
                cmp({e.nm, "_valB"},   256'(rfIf.valB),      256'(e.valB));
                cmp({e.nm, "_busyA"},  256'(rfIf.busyA),     256'(e.busyA));
                cmp({e.nm, "_busyB"},  256'(rfIf.busyB),     256'(e.busyB));
                cmp({e.nm, "_hazard"}, 256'(rfIf.hazard),    256'(e.busyA | e.busyB));
                cmp({e.nm, "_flat"},   256'(rfIf.regs_flat), 256'(e.flat));
            end
        end
    end

    task automatic check(input string nm, input logic [DW-1:0] eA, input logic [DW-1:0] eB,
                         input logic ebA, input logic ebB);
        exp_t x;
        x.nm    = nm;
        x.valA  = eA;
        x.valB  = eB;
        x.busyA = ebA;
        x.busyB = ebB;
        x.flat  = '0;
        for (int i = 0; i < NR; i++) x.flat[i*DW +: DW] = expRegs[i];
        q.push_back(x);
        chkReq = 1'b1;
        @(negedge clock);
        #1 chkReq = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rfIf.dstE    = 4'd15;
        rfIf.valE    = '0;
        rfIf.dstM    = 4'd15;
        rfIf.valM    = '0;
        rfIf.rsv_en  = 1'b0;
        rfIf.rsv_dst = 4'd15;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        chkReq = 1'b0;
        for (int i = 0; i < NR; i++) expRegs[i] = '0;
        reset = 1'b0;
        idle();
        rfIf.srcA = 4'd3;
        rfIf.srcB = 4'd0;
        #12 check("in_reset", 0, 0, 0, 0);
        #16 reset = 1'b1;

        tick(); rfIf.srcA = 4'd3;
        check("rst_rd3", 0, 0, 0, 0);

        tick(); rfIf.dstE = 4'd2; rfIf.valE = 32'hABCDEF98; rfIf.dstM = 4'd5; rfIf.valM = 32'h7654321A;
        rfIf.srcA = 4'd2; rfIf.srcB = 4'd5;
        check("dual_pre", BYP ? 32'hABCDEF98 : 32'h0, BYP ? 32'h7654321A : 32'h0, 0, 0);
        tick(); idle(); expRegs[2] = 32'hABCDEF98; expRegs[5] = 32'h7654321A;
        check("dual_rd", 32'hABCDEF98, 32'h7654321A, 0, 0);

        tick(); rfIf.dstE = 4'd4; rfIf.valE = 32'h11111111; rfIf.dstM = 4'd4; rfIf.valM = 32'h22222222;
        rfIf.srcA = 4'd4; rfIf.srcB = 4'd0;
        check("coll_pre", BYP ? 32'h22222222 : 32'h0, 0, 0, 0);
        tick(); idle(); expRegs[4] = 32'h22222222;
        check("coll_rd", 32'h22222222, 0, 0, 0);

        tick(); rfIf.dstE = 4'd15; rfIf.valE = 32'hDEADBEEF; rfIf.dstM = 4'd9; rfIf.valM = 32'hCAFEF00D;
        rfIf.srcA = 4'd15; rfIf.srcB = 4'd9;
        check("rnone_pre", 0, 0, 0, 0);
        tick(); idle(); rfIf.srcB = 4'd2;
        check("rnone_rd", 0, 32'hABCDEF98, 0, 0);

        tick(); rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd6; rfIf.srcA = 4'd6; rfIf.srcB = 4'd6;
        check("rsv_pre", 0, 0, 0, 0);
        tick(); idle();
        check("rsv_busy", 0, 0, 1, 1);

        tick(); rfIf.dstM = 4'd6; rfIf.valM = 32'h66; rfIf.srcB = 4'd0;
        check("clr_pre", BYP ? 32'h66 : 32'h0, 0, !BYP, 0);
        tick(); idle(); expRegs[6] = 32'h66;
        check("clr_rd", 32'h66, 0, 0, 0);

        tick(); rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd6; rfIf.dstE = 4'd6; rfIf.valE = 32'h77;
        check("rsvwr_pre", BYP ? 32'h77 : 32'h66, 0, 0, 0);
        tick(); idle(); expRegs[6] = 32'h77;
        check("rsvwr_rd", 32'h77, 0, 1, 0);

        tick(); rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd15; rfIf.srcA = 4'd7; rfIf.srcB = 4'd6;
        check("rsvnone_pre", 0, 32'h77, 0, 1);
        tick(); idle(); rfIf.srcB = 4'd15;
        check("rsvnone_rd", 0, 0, 0, 0);

        tick(); rfIf.srcA = 4'd6; rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd6;
        check("rerv_pre", 32'h77, 0, 1, 0);
        tick(); idle(); rfIf.dstE = 4'd6; rfIf.valE = 32'h99;
        check("rerv_wr", BYP ? 32'h99 : 32'h77, 0, !BYP, 0);
        tick(); idle(); expRegs[6] = 32'h99;
        check("rerv_clr", 32'h99, 0, 0, 0);

        tick(); rfIf.dstE = 4'd1; rfIf.valE = 32'h13579BDF; rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd1;
        rfIf.srcA = 4'd1; rfIf.srcB = 4'd15;
        check("r1_pre", BYP ? 32'h13579BDF : 32'h0, 0, 0, 0);
        tick(); idle(); expRegs[1] = 32'h13579BDF;
        check("r1_rd", 32'h13579BDF, 0, 1, 0);

        tick(); rfIf.dstM = 4'd1; rfIf.valM = 32'hFFFFFFFF; rfIf.rsv_en = 1'b1; rfIf.rsv_dst = 4'd2;
        reset = 1'b0;
        for (int i = 0; i < NR; i++) expRegs[i] = '0;
        check("async_rst", 0, 0, 0, 0);
        tick();
        check("rst_hold", 0, 0, 0, 0);
        tick(); reset = 1'b1; idle(); rfIf.srcB = 4'd2;
        check("rst_rel", 0, 0, 0, 0);

        tick(); rfIf.dstM = 4'd3; rfIf.valM = 32'h00000BEE; rfIf.srcA = 4'd0; rfIf.srcB = 4'd0;
        tick(); idle(); expRegs[3] = 32'h00000BEE;
        rfIf.srcA = 4'd3; rfIf.dstE = 4'd3; rfIf.valE = 32'h0000CAFE;
        check("byp_pre", BYP ? 32'h0000CAFE : 32'h00000BEE, 0, 0, 0);
        tick(); idle(); expRegs[3] = 32'h0000CAFE;
        check("byp_rd", 32'h0000CAFE, 0, 0, 0);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's 8x32 register file.
- Adds configurable width and depth, an explicit "no register" code, two combinational read ports, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between the decode stage (reads and reservations) and the write-back stage (dstE/dstM writes).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 8: number of architectural registers; legal range 2..16.
- ADDR_W, 4: width of all register-ID ports.
- RNONE, 15: register ID meaning "no register". Must be >= NUM_REGS.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- dstE, input, ADDR_W: E-port write target.
- valE, input, DATA_W: E-port write data.
- dstM, input, ADDR_W: M-port write target.
- valM, input, DATA_W: M-port write data.
- srcA, input, ADDR_W: read port A address.
- srcB, input, ADDR_W: read port B address.
- valA, output, DATA_W: read port A data (combinational).
- valB, output, DATA_W: read port B data (combinational).
- rsv_en, input, 1: reserve request; marks rsv_dst busy.
- rsv_dst, input, ADDR_W: register to reserve.
- busyA, output, 1: srcA has a pending write.
- busyB, output, 1: srcB has a pending write.
- hazard, output, 1: busyA | busyB.
- regs_flat, output, NUM_REGS*DATA_W: all registers for debug. Register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (reset==0, asynchronous):
  - All registers clear to 0.
  - All busy bits clear to 0.
  - Outputs follow at once: valA, valB, regs_flat read 0; busyA, busyB, hazard read 0.
  - Reset asserted mid-operation discards any write or reservation in flight.
- Valid IDs: an ID is valid only if it is < NUM_REGS. Any other ID, including RNONE, is ignored:
  - as a write target: no write;
  - as a read address: data 0, busy 0;
  - as a reservation: no-op.
- Writes (posedge clock, reset==1):
  - reg[dstE] <= valE when dstE is valid.
  - reg[dstM] <= valM when dstM is valid.
  - dstE == dstM (both valid): valM wins; E data is dropped.
  - Write latency is 1 cycle: the new value is visible on regs_flat and the read ports after the edge.
- Scoreboard (posedge clock):
  - Set busy[rsv_dst] when rsv_en is high and rsv_dst is valid.
  - Clear busy[dstE] when dstE is valid; clear busy[dstM] when dstM is valid.
  - Reserve and write to the same register in the same cycle: the set wins and the bit stays/becomes 1. This covers a new producer issuing while the old one retires.
  - Reserving an already-busy register: the bit stays 1. There is no count; a single write clears it.
- Reads (combinational):
  - valA = reg[srcA]; busyA = busy[srcA]. Port B likewise.
  - Without the optional feature, a read of a register being written in the current cycle returns the old value.
- No internal state besides registers and busy bits. Unused high bits of ID ports are don't-care only through the validity check.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - valA and valB forward same-cycle write data. If srcX == dstM (valid), return valM; else if srcX == dstE (valid), return valE; else return the register value.
  - busyX is forced to 0 when srcX matches a valid dstE or dstM in that cycle, unless rsv_dst == srcX with rsv_en high.
  - hazard follows the forced busy values.
- Undefined: no forwarding; reads and busy reflect registered state only.

Test Plan:
- Reset then release: hold reset=0 for 37ns, set reset=1 -> regs_flat all 0, busyA/B=0, hazard=0; srcA=3 -> valA=0.
- Dual write, distinct registers: dstE=2 with valE=32'hABCDEF98, dstM=5 with valM=32'h7654321A, one edge -> reg2=ABCDEF98, reg5=7654321A; srcA=2, srcB=5 read both values.
- Same-target collision: dstE=dstM=4, valE=11111111, valM=22222222 -> reg4=22222222; dstE=RNONE=15 with valE=DEADBEEF -> no register changes.
- Scoreboard: rsv_en=1, rsv_dst=6 -> busy6=1; srcA=6 -> busyA=1, hazard=1. Next cycle dstM=6 -> busy6=0. Reserve and dstE on 6 in the same cycle -> busy6 remains 1.
- Async reset mid-stream: register 1 holds a nonzero value, busy1=1; drop reset between clock edges -> reg1=0 and busy1=0 immediately, with no clock edge.
- Bypass (REGFILE_BYPASS_EN defined): dstE=3, valE=0000CAFE, srcA=3 in the same cycle -> valA=0000CAFE before the edge. Same stimulus with the macro undefined -> valA shows the old reg3 value.
